// File: rtl/q2_alu_pkg.sv
// rtl/q2_alu_pkg.sv - shared op/state enums and default width for the q2 ALU sequencer
package q2_alu_pkg;

    localparam int Q2_WIDTH = 12;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_NOR  = 2'b01,
        OP_ADD  = 2'b10,
        OP_SHR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/q2_alu_ref.sv
// rtl/q2_alu_ref.sv - behavioural model of the q2 1-bit ALU slice
module q2_alu_ref
    import q2_alu_pkg::*;
(
    input  logic i_a0,
    input  logic i_x0,
    input  logic i_x1,
    input  logic i_f,
    input  logic i_o0,
    input  logic i_o1,
    output logic o_out,
    output logic o_cout
);

    op_e w_op;

    assign w_op = op_e'({i_o1, i_o0});

    // PASS/NOR fold the result into a running zero flag; ADD ripples; SHR keeps the carry.
    always_comb begin
        o_out  = 1'b0;
        o_cout = 1'b0;
        case (w_op)
            OP_PASS: begin
                o_out  = i_x0;
                o_cout = i_f & ~i_x0;
            end
            OP_NOR: begin
                o_out  = ~(i_a0 | i_x0);
                o_cout = i_f & (i_a0 | i_x0);
            end
            OP_ADD: begin
                o_out  = i_a0 ^ i_x0 ^ i_f;
                o_cout = (i_a0 & i_x0) | (i_a0 & i_f) | (i_x0 & i_f);
            end
            OP_SHR: begin
                o_out  = i_x1;
                o_cout = i_f;
            end
            default: begin
                o_out  = 1'b0;
                o_cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/q2_alu_seq.sv
// rtl/q2_alu_seq.sv - bit-serial sequencer for the q2 ALU slice; Q2_ALU_SEQ_CHECK_EN adds slice checking and alu_err
module q2_alu_seq
    import q2_alu_pkg::*;
#(
    parameter int WIDTH = Q2_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             alu_a0,
    output logic             alu_x0,
    output logic             alu_x1,
    output logic             alu_f,
    output logic             alu_o0,
    output logic             alu_o1,
    input  logic             alu_out,
    input  logic             alu_cout
`ifdef Q2_ALU_SEQ_CHECK_EN
    ,
    output logic             alu_err
`endif
);

    state_e           r_state;
    state_e           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_xr;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic             r_carry;
    logic             r_done;
    logic             r_cout;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_acc_shift;

    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_acc_shift = {alu_out, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_xr     <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_carry  <= 1'b0;
            r_done   <= 1'b0;
            r_cout   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_acc   <= a_in;
                r_xr    <= x_in;
                r_op    <= op;
                // PASS/NOR start the zero flag at 1; the slice clears it on any 1 bit.
                r_carry <= op[1] ? cin : 1'b1;
                r_cnt   <= '0;
            end else if (r_state == ST_RUN) begin
                r_acc   <= w_acc_shift;
                r_xr    <= {1'b0, r_xr[WIDTH-1:1]};
                r_carry <= alu_cout;
                r_cnt   <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_result <= w_acc_shift;
                    r_cout   <= alu_cout;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign busy   = (r_state == ST_RUN);
    assign done   = r_done;
    assign result = r_result;
    assign cout   = r_cout;
    assign alu_a0 = r_acc[0];
    assign alu_x0 = r_xr[0];
    assign alu_x1 = w_last ? 1'b0 : r_xr[1];
    assign alu_f  = r_carry;
    assign alu_o0 = r_op[0];
    assign alu_o1 = r_op[1];

`ifdef Q2_ALU_SEQ_CHECK_EN
    logic w_ref_out;
    logic w_ref_cout;
    logic r_err;

    q2_alu_ref u_ref (
        .i_a0   (alu_a0),
        .i_x0   (alu_x0),
        .i_x1   (alu_x1),
        .i_f    (alu_f),
        .i_o0   (alu_o0),
        .i_o1   (alu_o1),
        .o_out  (w_ref_out),
        .o_cout (w_ref_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_RUN) &&
                     ((w_ref_out != alu_out) || (w_ref_cout != alu_cout))) begin
            r_err <= 1'b1;
        end
    end

    assign alu_err = r_err;
`endif

endmodule

// File: tb/tb_q2_alu_seq.sv
// tb/tb_q2_alu_seq.sv - directed self-checking bench for q2_alu_seq with the slice model attached
module tb_q2_alu_seq;

    localparam int W = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  x_in = '0;
    logic          cin = 1'b0;
    logic          busy, done, cout;
    logic [W-1:0]  result;
    logic          alu_a0, alu_x0, alu_x1, alu_f, alu_o0, alu_o1;
    logic          alu_out, alu_cout;
    logic          w_slice_out;
`ifdef Q2_ALU_SEQ_CHECK_EN
    logic          alu_err;
`endif

    int            n_chk = 0;
    int            n_err = 0;
    int            n_done = 0;
    bit            inject = 1'b0;
    bit            m_skip = 1'b0;

    int            m_phase = 0;
    logic [W-1:0]  m_res = '0, m_pend_res = '0;
    logic          m_cout = 1'b0, m_pend_cout = 1'b0;
    logic [1:0]    m_op = 2'b00;

    always #5 clk = ~clk;

    q2_alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .x_in     (x_in),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .alu_a0   (alu_a0),
        .alu_x0   (alu_x0),
        .alu_x1   (alu_x1),
        .alu_f    (alu_f),
        .alu_o0   (alu_o0),
        .alu_o1   (alu_o1),
        .alu_out  (alu_out),
        .alu_cout (alu_cout)
`ifdef Q2_ALU_SEQ_CHECK_EN
        ,
        .alu_err  (alu_err)
`endif
    );

    q2_alu_ref u_slice (
        .i_a0   (alu_a0),
        .i_x0   (alu_x0),
        .i_x1   (alu_x1),
        .i_f    (alu_f),
        .i_o0   (alu_o0),
        .i_o1   (alu_o1),
        .o_out  (w_slice_out),
        .o_cout (alu_cout)
    );

    // Fault hook: flips the slice result bit during run cycle 3 (phase 4).
    assign alu_out = w_slice_out ^ (inject && (m_phase == 4));

    function automatic logic [W:0] exp_calc(input logic [1:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] x, input logic c);
        logic [W-1:0] r;
        case (o)
            2'b00: return {(x == 0), x};
            2'b01: begin r = ~(a | x); return {(r == 0), r}; end
            2'b10: return ({1'b0, a} + {1'b0, x} + {{W{1'b0}}, c});
            default: return {c, x >> 1};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Phase 0 idle, 1..W run cycles, W+1 done cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_res = '0; m_cout = 1'b0; m_op = 2'b00;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase = 1;
                m_op = op;
                {m_pend_cout, m_pend_res} = exp_calc(op, a_in, x_in, cin);
            end
        end else if (m_phase < W) begin
            m_phase++;
        end else if (m_phase == W) begin
            m_phase = W + 1;
            m_res = m_pend_res;
            m_cout = m_pend_cout;
        end else begin
            m_phase = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (done) n_done++;
        chk("busy", busy, (m_phase >= 1 && m_phase <= W));
        chk("done", done, (m_phase == W + 1));
        chk("op_latch", {alu_o1, alu_o0}, m_op);
        if (!m_skip) begin
            chk("result", result, m_res);
            chk("cout", cout, m_cout);
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] x,
                          input logic c, input logic [W-1:0] er, input logic ec,
                          input string nm, input int restart_at);
        int lat;
        @(negedge clk);
        op = o; a_in = a; x_in = x; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == restart_at) begin
                start = 1'b1; a_in = ~a;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({nm, " latency"}, lat, 13);
        chk({nm, " result"}, result, er);
        chk({nm, " cout"}, cout, ec);
    endtask

    initial begin
        int n0;
        repeat (3) @(negedge clk);
        chk("reset flags", {busy, done, cout, alu_a0, alu_x0, alu_x1, alu_f, alu_o0, alu_o1}, 0);
        chk("reset result", result, 0);
        rst_n = 1'b1;

        run_op(2'b10, 12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, "add_7ff", 0);
        run_op(2'b10, 12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, "add_wrap", 0);
        run_op(2'b10, 12'hFFF, 12'h001, 1'b1, 12'h001, 1'b1, "add_wrap_cin", 0);
        run_op(2'b01, 12'h0F0, 12'h00F, 1'b0, 12'hF00, 1'b0, "nor_a", 0);
        run_op(2'b01, 12'hFFF, 12'h000, 1'b0, 12'h000, 1'b1, "nor_zero", 0);
        run_op(2'b00, 12'hABC, 12'h000, 1'b0, 12'h000, 1'b1, "pass_zero", 0);
        run_op(2'b00, 12'h000, 12'h804, 1'b1, 12'h804, 1'b0, "pass_nz", 0);
        run_op(2'b11, 12'h000, 12'h005, 1'b1, 12'h002, 1'b1, "shr", 0);
        run_op(2'b11, 12'hFFF, 12'hFFF, 1'b0, 12'h7FF, 1'b0, "shr_full", 0);

        n0 = n_done;
        run_op(2'b10, 12'h123, 12'h456, 1'b0, 12'h579, 1'b0, "restart_ign", 4);
        repeat (15) @(negedge clk);
        chk("restart single done", n_done - n0, 1);

        @(negedge clk);
        op = 2'b10; a_in = 12'h0AB; x_in = 12'h101; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun reset flags", {busy, done, cout, alu_a0, alu_x0, alu_x1, alu_f, alu_o0, alu_o1}, 0);
        chk("midrun reset result", result, 0);
        n0 = n_done;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (16) @(negedge clk);
        chk("no done after reset", n_done - n0, 0);
        run_op(2'b10, 12'h0AB, 12'h101, 1'b1, 12'h1AD, 1'b0, "after_reset", 0);

`ifdef Q2_ALU_SEQ_CHECK_EN
        begin
            int lat;
            chk("err clear", alu_err, 0);
            m_skip = 1'b1;
            inject = 1'b1;
            @(negedge clk);
            op = 2'b00; a_in = 12'h000; x_in = 12'h000; cin = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            lat = 1;
            while (!done && lat < 40) begin
                chk("err timing", alu_err, (lat >= 5));
                @(negedge clk);
                lat++;
            end
            chk("err latency", lat, 13);
            repeat (3) @(negedge clk);
            chk("err sticky", alu_err, 1);
            inject = 1'b0;
            @(negedge clk);
            op = 2'b01; a_in = 12'h0F0; x_in = 12'h00F; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("err cleared by start", alu_err, 0);
            lat = 1;
            while (!done && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            chk("err post result", result, 12'hF00);
            m_skip = 1'b0;
        end
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/q2_alu_seq.md
Name: q2_alu_seq

Overview:
Bit-serial sequencer that drives the q2 1-bit ALU slice and writes its results back.
- Holds the accumulator, operand and carry flag.
- Each cycle it presents the current LSBs, op select and carry flag to the slice, then shifts the slice's result bit and carry-out back in.
- A WIDTH-bit operation completes in WIDTH run cycles. The core control FSM issues ALU ops through a start/done handshake.

Parameters:
WIDTH, 12, word width in bits (>=2)
CNT_W, $clog2(WIDTH), bit-counter width (derived; not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin operation; sampled only in IDLE
op  input  2  {o1,o0}: 00 pass X, 01 NOR, 10 ADD, 11 shift-right X
a_in  input  WIDTH  accumulator operand
x_in  input  WIDTH  X operand
cin  input  1  carry flag in
busy  output  1  operation in progress
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  accumulator after operation
cout  output  1  carry flag after operation
alu_a0  output  1  to slice a0: acc[0]
alu_x0  output  1  to slice x0: xr[0]
alu_x1  output  1  to slice x1: xr[1]; 0 on last bit
alu_f  output  1  to slice f: carry register
alu_o0  output  1  latched op[0]
alu_o1  output  1  latched op[1]
alu_out  input  1  from slice: result bit
alu_cout  input  1  from slice: next carry

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; acc, xr, cnt and op register cleared; carry=0.
  - All outputs 0: busy, done, result, cout, alu_*.
- IDLE: start=1 loads acc=a_in, xr=x_in and op register=op.
  - Carry loads cin for op 10/11.
  - Carry loads 1 for op 00/01, since the slice ANDs carry with ~out, giving a zero flag.
  - cnt=0. Go to RUN; busy=1 from the next cycle.
- RUN: each cycle the slice inputs come combinationally from registers. On the clock edge:
  - acc shifts right with alu_out into acc[WIDTH-1].
  - xr shifts right with 0 into the MSB.
  - carry loads alu_cout.
  - cnt increments.
- Last RUN cycle: at cnt=WIDTH-1, go to DONE after the edge. Latency from start to done is WIDTH+1 cycles.
- DONE: done=1 for exactly one cycle; busy=0; result=acc; cout=carry; return to IDLE.
- result and cout hold their value until the next DONE.
- start while in RUN or DONE is ignored. It is not queued.
- Op semantics at completion:
  - 00: result=X; cout=(X==0).
  - 01: result=~(A|X); cout=(result==0).
  - 10: result=A+X+cin mod 2^WIDTH; cout=carry out of MSB.
  - 11: result=X>>1; cout=cin.
- alu_o0/alu_o1 are driven from the latched op register only, never from the op port directly.
- Reset asserted mid-RUN aborts the operation: no done pulse, and result and cout clear to 0.

Optional Feature:
Q2_ALU_SEQ_CHECK_EN
- Defined:
  - Adds an internal behavioural model of the slice (sum/carry, NOR, pass, x1 select, carry-select rules) that is compared against alu_out/alu_cout on every RUN cycle.
  - Adds port alu_err (output, 1): sticky, set on the first mismatch, cleared by reset or by a start accepted in IDLE.
- Undefined: no model, no alu_err port, zero extra logic.

Decomposition:
- Package q2_alu_pkg:
  - op enum: OP_PASS=2'b00, OP_NOR=2'b01, OP_ADD=2'b10, OP_SHR=2'b11.
  - FSM state enum: ST_IDLE, ST_RUN, ST_DONE.
  - Default WIDTH constant.
- Sub-module: q2_alu_ref, the behavioural slice model. It is instantiated only under Q2_ALU_SEQ_CHECK_EN and is reused by the bench as a scoreboard.

Test Plan:
- Bench uses WIDTH=12 with the slice connected.
- ADD a_in=0x7FF, x_in=0x001, cin=0 -> done on cycle 13 after start; result=0x800, cout=0.
- ADD a_in=0xFFF, x_in=0x001, cin=0 -> result=0x000, cout=1. Same with cin=1 -> result=0x001, cout=1.
- NOR a_in=0x0F0, x_in=0x00F -> result=0xF00, cout=0. NOR a_in=0xFFF, x_in=0x000 -> result=0x000, cout=1.
- PASS x_in=0x000 -> result=0x000, cout=1. SHR x_in=0x005, cin=1 -> result=0x002, cout=1.
- start re-pulsed mid-RUN -> ignored, single done, result unchanged. rst_n low at cnt=5 -> all outputs 0, no done pulse, next op completes correctly.
- CHECK_EN build with alu_out forced inverted on bit 3 -> alu_err rises the cycle after the mismatch, stays 1 until the next accepted start.
